// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: takes one ALU operation at a time and performs
// a word load or store against a local data memory after a fixed latency.
module mem_access_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ALUResult,
  input  logic [31:0] writeData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        out_valid,
  output logic [31:0] readData,
  output logic [31:0] ALUResultOut,
  output logic        addr_err
);
  // state  | meaning
  // IDLE   | waiting for an operation, in_ready high
  // ACCESS | memory busy; cnt_q counts down, zero marks the final cycle
  // DONE   | one-cycle result pulse on out_valid

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] read_data_q, read_data_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          mem_op;
  logic          misaligned;
  logic          out_of_range;
  logic          conflict;
  logic          fault;
  logic          final_access;
  logic          mem_we;
  logic [AW-1:0] mem_idx;

  assign accept       = in_valid && in_ready_q;
  assign mem_op       = MemRead || MemWrite;
  assign misaligned   = ALUResult[1:0] != 2'b00;
  // Full-width compare so high address bits can never alias into the array.
  assign out_of_range = {2'b00, ALUResult[31:2]} >= 32'(DEPTH_WORDS);
  assign conflict     = MemRead && MemWrite;
  assign fault        = mem_op && (misaligned || out_of_range || conflict);
  assign mem_idx      = addr_q[AW+1:2];
  assign final_access = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign mem_we       = final_access && wr_q && !reset;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    out_valid_d = 1'b0;
    read_data_d = read_data_q;
    alu_out_d   = alu_out_q;
    addr_err_d  = addr_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = ALUResult;
          wdata_d = writeData;
          rd_d    = MemRead;
          wr_d    = MemWrite;
          if (!mem_op || fault) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            read_data_d = 32'd0;
            alu_out_d   = ALUResult;
            addr_err_d  = fault;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          read_data_d = rd_q ? mem[mem_idx] : 32'd0;
          alu_out_d   = addr_q;
          addr_err_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      read_data_q <= 32'd0;
      alu_out_q   <= 32'd0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      read_data_q <= read_data_d;
      alu_out_q   <= alu_out_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= wdata_q;
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign readData     = read_data_q;
  assign ALUResultOut = alu_out_q;
  assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a reference model pushes expected
// results into a queue at accept; a negedge monitor pops and compares them.
module tb_mem_access_stage;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] ALUResult, writeData;
  logic        MemRead, MemWrite;
  logic        out_valid, addr_err;
  logic [31:0] readData, ALUResultOut;

  logic        l_in_valid, l_in_ready;
  logic [31:0] l_ALUResult, l_writeData;
  logic        l_MemRead, l_MemWrite;
  logic        l_out_valid, l_addr_err;
  logic [31:0] l_readData, l_ALUResultOut;

  always #5 clk = ~clk;

  mem_access_stage #(.DEPTH_WORDS(256), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUResult(ALUResult), .writeData(writeData), .MemRead(MemRead), .MemWrite(MemWrite),
    .out_valid(out_valid), .readData(readData), .ALUResultOut(ALUResultOut), .addr_err(addr_err)
  );

  mem_access_stage #(.DEPTH_WORDS(256), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .ALUResult(l_ALUResult), .writeData(l_writeData), .MemRead(l_MemRead), .MemWrite(l_MemWrite),
    .out_valid(l_out_valid), .readData(l_readData), .ALUResultOut(l_ALUResultOut), .addr_err(l_addr_err)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [256];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_due = -1;
  logic [31:0] last_alu = 32'd0;
  logic [31:0] last_rd = 32'd0;
  logic        last_err = 1'b0;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_out_valid observed=1 expected=0 (no pending op)");
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("out_cycle", 32'(cyc), 32'(mon_e.due));
        chk("alu_out", ALUResultOut, mon_e.alu);
        chk("read_data", readData, mon_e.rdata);
        chk("addr_err", 32'(addr_err), 32'(mon_e.err));
        last_alu = mon_e.alu;
        last_rd  = mon_e.rdata;
        last_err = mon_e.err;
      end
    end else if (reset === 1'b0) begin
      chk("hold_alu_out", ALUResultOut, last_alu);
      chk("hold_read_data", readData, last_rd);
      chk("hold_addr_err", 32'(addr_err), 32'(last_err));
    end
  end

  task automatic push_expect();
    exp_t e;
    logic mop, flt;
    mop = MemRead || MemWrite;
    flt = mop && (ALUResult[1:0] != 2'b00 || ALUResult[31:10] != 22'd0 || (MemRead && MemWrite));
    e.alu   = ALUResult;
    e.err   = flt;
    e.rdata = (mop && !flt && MemRead) ? mdl[ALUResult[9:2]] : 32'd0;
    if (mop && !flt && MemWrite) mdl[ALUResult[9:2]] = writeData;
    e.due   = cyc + ((mop && !flt) ? LAT + 1 : 1);
    last_due = e.due;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr);
    ALUResult = a; writeData = wd; MemRead = rd; MemWrite = wr; in_valid = 1'b1;
  endtask

  task automatic tick(output bit acc);
    @(negedge clk);
    acc = 1'b0;
    if (reset === 1'b0) begin
      chk("in_ready", 32'(in_ready), 32'(cyc > last_due));
      if (in_valid && in_ready === 1'b1) begin
        push_expect();
        acc = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr);
    bit acc;
    int g;
    drive(a, wd, rd, wr);
    g = 0; acc = 1'b0;
    while (!acc && g < 20) begin tick(acc); g++; end
    in_valid = 1'b0;
    chk("accept_timeout", 32'(acc), 32'd1);
    repeat (LAT + 3) tick(acc);
  endtask

  task automatic clear_last();
    last_alu = 32'd0; last_rd = 32'd0; last_err = 1'b0; last_due = -1;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_read_data"}, readData, 32'd0);
    chk({tag, "_alu_out"}, ALUResultOut, 32'd0);
    chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic lat1_op(input string tag, input logic [31:0] a, input logic [31:0] wd,
                         input logic rd, input logic wr, input logic [31:0] exp_rd);
    int c, g;
    l_ALUResult = a; l_writeData = wd; l_MemRead = rd; l_MemWrite = wr; l_in_valid = 1'b1;
    @(negedge clk);
    c = cyc;
    chk({tag, "_ready"}, 32'(l_in_ready), 32'd1);
    @(posedge clk); #1;
    l_in_valid = 1'b0;
    g = 0;
    do begin @(negedge clk); g++; end while (l_out_valid !== 1'b1 && g < 10);
    chk({tag, "_out_cycle"}, 32'(cyc - c), 32'd2);
    chk({tag, "_read_data"}, l_readData, exp_rd);
    chk({tag, "_addr_err"}, 32'(l_addr_err), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int g;
    in_valid = 1'b0; ALUResult = 32'd0; writeData = 32'd0; MemRead = 1'b0; MemWrite = 1'b0;
    l_in_valid = 1'b0; l_ALUResult = 32'd0; l_writeData = 32'd0; l_MemRead = 1'b0; l_MemWrite = 1'b0;

    // in_valid asserted during reset must be ignored
    reset = 1'b1;
    drive(32'h55, 32'd0, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0; in_valid = 1'b0;
    clear_last();
    check_reset_vals("reset");

    op(32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
    op(32'h10, 32'd0, 1'b1, 1'b0);
    op(32'h1234, 32'h77, 1'b0, 1'b0);

    op(32'h13, 32'd0, 1'b1, 1'b0);
    op(32'h400, 32'd0, 1'b1, 1'b0);
    op(32'h20, 32'h20202020, 1'b0, 1'b1);
    op(32'h20, 32'h00000BAD, 1'b1, 1'b1);
    op(32'h20, 32'd0, 1'b1, 1'b0);
    op(32'h40000010, 32'h0BADBAD0, 1'b0, 1'b1);
    op(32'h80000010, 32'd0, 1'b1, 1'b0);
    op(32'h10, 32'd0, 1'b1, 1'b0);

    op(32'h3FC, 32'h600DF00D, 1'b0, 1'b1);
    op(32'h3FC, 32'd0, 1'b1, 1'b0);

    // in_valid held high while the presented operation changes every cycle
    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0:       drive((i % 8 == 0) ? 32'h10 : 32'h100 + 32'(i * 4), 32'hA5000000 | 32'(i), 1'b0, 1'b1);
        1:       drive(32'h2000 + 32'(i), 32'd0, 1'b0, 1'b0);
        2:       drive(32'h10, 32'd0, 1'b1, 1'b0);
        default: drive(32'h101 + 32'(i), 32'd0, 1'b1, 1'b0);
      endcase
      tick(acc);
    end
    in_valid = 1'b0;
    repeat (LAT + 4) tick(acc);

    // reset lands on the first ACCESS cycle of a store
    op(32'h40, 32'h11111111, 1'b0, 1'b1);
    drive(32'h40, 32'hCAFEF00D, 1'b0, 1'b1);
    @(negedge clk);
    chk("abort_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_last();
    check_reset_vals("abort_reset");
    repeat (5) tick(acc);
    op(32'h40, 32'd0, 1'b1, 1'b0);

    lat1_op("lat1_store", 32'h3FC, 32'h5A5A1234, 1'b0, 1'b1, 32'd0);
    lat1_op("lat1_load", 32'h3FC, 32'd0, 1'b1, 1'b0, 32'h5A5A1234);

    g = 0;
    while (sb.size() != 0 && g < 20) begin tick(acc); g++; end
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
